// File: rtl/fp_pkg.sv
// Shared half-precision helpers for ip_fp_addsub, its result buffer and benches.
// Word layout {sign, exponent, fraction}; status bit indices for the 8-bit status.
package fp_pkg;

  localparam int unsigned P_EXP_D  = 5;
  localparam int unsigned P_FRAC_D = 10;
  localparam int unsigned P_BIAS_D = 15;

  localparam int unsigned ST_ZERO    = 0;
  localparam int unsigned ST_INF     = 1;
  localparam int unsigned ST_INVALID = 2;
  localparam int unsigned ST_TINY    = 3;
  localparam int unsigned ST_HUGE    = 4;
  localparam int unsigned ST_INEXACT = 5;
  localparam int unsigned ST_HUGEINT = 6;
  localparam int unsigned ST_COMP    = 7;

  function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  // Words are passed zero-extended to 64 bits so one function serves any format.
  function automatic logic is_nan(input logic [63:0] word, input int unsigned exp_w,
                                  input int unsigned frac_w);
    logic [63:0] frac_mask;
    logic [63:0] exp_mask;
    frac_mask = (64'd1 << frac_w) - 64'd1;
    exp_mask  = ((64'd1 << exp_w) - 64'd1) << frac_w;
    return ((word & exp_mask) == exp_mask) && ((word & frac_mask) != 64'd0);
  endfunction

  function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned frac_w);
    logic [63:0] exp_mask;
    exp_mask = ((64'd1 << exp_w) - 64'd1) << frac_w;
    return exp_mask | (64'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with registered head data, empty and full flags.
// Pointers carry one extra wrap bit; push is ignored when full, pop when empty.
module fp_sync_fifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_nxt  = rd_ptr + PW'(do_pop);
    wr_nxt  = wr_ptr + PW'(do_push);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Head register tracks the next head; a slot written this cycle forwards din.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      dout   <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      if (do_push && (rd_nxt == wr_ptr)) dout <= din;
      else                               dout <= mem[rd_nxt[AW-1:0]];
      empty <= (rd_nxt == wr_nxt);
      full  <= (rd_nxt[AW] != wr_nxt[AW]) && (rd_nxt[AW-1:0] == wr_nxt[AW-1:0]);
    end
  end

endmodule

// File: rtl/fp_addsub_result_buf.sv
// Result buffer behind ip_fp_addsub: FIFO with valid/ready output, sticky flags, counters.
// Optional macro FP_NAN_CANON_EN stores every NaN result as the canonical quiet NaN.
module fp_addsub_result_buf
  import fp_pkg::*;
#(
  parameter int unsigned P_EXP   = P_EXP_D,
  parameter int unsigned P_FRAC  = P_FRAC_D,
  parameter int unsigned P_BIAS  = P_BIAS_D,
  parameter int unsigned P_WORD  = word_w(P_EXP, P_FRAC),
  parameter int unsigned P_DEPTH = 4,
  parameter int unsigned P_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  input  logic [P_WORD-1:0]  in_z,
  input  logic [7:0]         in_status,
  output logic               in_rdy,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [P_WORD-1:0]  out_z,
  output logic [7:0]         out_status,
  output logic [7:0]         flags,
  input  logic               flags_clr,
  output logic [P_CNT_W-1:0] res_cnt,
  output logic [P_CNT_W-1:0] drop_cnt
);

  localparam int unsigned EW = P_WORD + 8;

  // Elaboration-time guard on the parameter set.
  if ((P_BIAS != (2 ** (P_EXP - 1)) - 1) || (P_DEPTH < 2) ||
      ((P_DEPTH & (P_DEPTH - 1)) != 0)) begin : g_param_chk
    $error("fp_addsub_result_buf: inconsistent P_BIAS or P_DEPTH");
  end

  logic              push, drop, pop;
  logic              fifo_full, fifo_empty;
  logic [P_WORD-1:0] z_store;
  logic [EW-1:0]     head;

  always_comb begin
    push = in_vld && !fifo_full;
    drop = in_vld && fifo_full;
    pop  = !fifo_empty && out_rdy;
  end

`ifdef FP_NAN_CANON_EN
  always_comb begin
    z_store = in_z;
    if (is_nan(64'(in_z), P_EXP, P_FRAC)) z_store = P_WORD'(canon_nan(P_EXP, P_FRAC));
  end
`else
  always_comb z_store = in_z;
`endif

  fp_sync_fifo #(
    .W     (EW),
    .DEPTH (P_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({z_store, in_status}),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    in_rdy     = !fifo_full;
    out_vld    = !fifo_empty;
    out_z      = head[EW-1:8];
    out_status = head[7:0];
  end

  // Clear takes effect before the OR so a simultaneous push survives.
  always_ff @(posedge clk) begin
    if (!rst_n) flags <= '0;
    else        flags <= (flags_clr ? 8'h00 : flags) | (push ? in_status : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push && (res_cnt != '1))  res_cnt  <= res_cnt + P_CNT_W'(1);
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + P_CNT_W'(1);
    end
  end

endmodule
